// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CMD_RD_BIT = 7;
    localparam int unsigned CMD_ADDR_W = 7;
    localparam int unsigned BIT_CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } spi_state_t;

    // True when the bit counter points at the last bit of a byte.
    function automatic logic last_bit(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == BIT_CNT_W'(BYTE_W - 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synced level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    // Synchronizer chain plus one flop holding the previous synced sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave bridging command/data frames onto a simple register bus.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = CMD_ADDR_W
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [BYTE_W-1:0] rd_data
);

    localparam int unsigned FLUSH_N = SYNC_STAGES + 1;
    localparam int unsigned FLUSH_W = $clog2(FLUSH_N + 1);

    logic sclk_rise;
    logic sclk_fall;

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   ss_prev_q;
    logic                   mosi_sync;
    logic                   ss_sync;
    logic                   ss_rise;
    logic                   ss_fall;

    logic [FLUSH_W-1:0] flush_q;
    logic               armed_q;

    spi_state_t          state_q,     state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [BYTE_W-2:0]   shift_in_q,  shift_in_d;
    logic [BYTE_W-1:0]   shift_out_q, shift_out_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                load_q,      load_d;
    logic                miso_q,      miso_d;
    logic                wr_valid_q,  wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
    logic [BYTE_W-1:0]   wr_data_q,   wr_data_d;
    logic                rd_req_q,    rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
    logic [BYTE_W-1:0]   rx_byte;

    // SCLK synchronizer with edge detection.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_LEVEL  (1'b0)
    ) u_sclk_sync (
        .clk    (clk_clk),
        .rst    (reset_reset),
        .din    (spi_sclk),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    // Plain synchronizers for MOSI and SS_n; SS_n keeps one extra sample for its edges.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            ss_prev_q   <= 1'b1;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];
    assign ss_sync   = ss_sync_q[SYNC_STAGES-1];
    assign ss_rise   = ss_sync & ~ss_prev_q;
    assign ss_fall   = ~ss_sync & ss_prev_q;

    // Arm frame start only after the chain has flushed and SS_n was seen high,
    // so a select held low across reset cannot start a phantom frame.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            flush_q <= '0;
            armed_q <= 1'b0;
        end else begin
            if (flush_q != FLUSH_W'(FLUSH_N)) begin
                flush_q <= flush_q + FLUSH_W'(1);
            end
            if (flush_q == FLUSH_W'(FLUSH_N) && ss_sync) begin
                armed_q <= 1'b1;
            end
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // Next-state logic: SS_n release wins over everything, then MISO shifting, then per-state byte handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        load_d      = 1'b0;
        miso_d      = miso_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        rx_byte     = {shift_in_q, mosi_sync};

        if (ss_rise) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            shift_out_d = '0;
            miso_d      = 1'b0;
        end else begin
            // Read data arrives the cycle after rd_req; load it one cycle later still.
            load_d = rd_req_q;
            if (load_q) begin
                shift_out_d = rd_data;
            end else if (sclk_fall && state_q != ST_IDLE) begin
                miso_d      = shift_out_q[BYTE_W-1];
                shift_out_d = {shift_out_q[BYTE_W-2:0], 1'b0};
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (ss_fall && armed_q) begin
                        state_d     = ST_CMD;
                        bit_cnt_d   = '0;
                        shift_in_d  = '0;
                        shift_out_d = '0;
                        miso_d      = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_in_d = rx_byte[BYTE_W-2:0];
                        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit(bit_cnt_q)) begin
                            if (rx_byte[CMD_RD_BIT]) begin
                                state_d   = ST_RDATA;
                                rd_req_d  = 1'b1;
                                rd_addr_d = ADDR_W'(rx_byte[CMD_ADDR_W-1:0]);
                                addr_d    = ADDR_W'(rx_byte[CMD_ADDR_W-1:0]) + ADDR_W'(1);
                            end else begin
                                state_d = ST_WDATA;
                                addr_d  = ADDR_W'(rx_byte[CMD_ADDR_W-1:0]);
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_in_d = rx_byte[BYTE_W-2:0];
                        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit(bit_cnt_q)) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = rx_byte;
                            addr_d     = addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_rise) begin
                        shift_in_d = rx_byte[BYTE_W-2:0];
                        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit(bit_cnt_q)) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = addr_q;
                            addr_d    = addr_q + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~ss_sync;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: SPI master driver, register bank, frame-level model.
module tb_spi_reg_slave;
    import spi_reg_pkg::*;

    localparam int HALF = 4;  // clk cycles per sclk half period (sclk = clk/8)

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t    exp_wr_q[$];
    logic [6:0] exp_rd_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] ref_mem [128];
    logic [7:0] bank_mem [128];
    logic       bank_fixed;

    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    spi_reg_slave #(
        .SYNC_STAGES (2),
        .ADDR_W      (7)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_ss_n    (spi_ss_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // Register bank on the system side.
    always @(posedge clk_clk) begin
        if (wr_valid) bank_mem[wr_addr] <= wr_data;
        if (rd_req) rd_data <= bank_fixed ? (8'h40 + {1'b0, rd_addr}) : bank_mem[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected bus events whenever the DUT strobes.
    always @(negedge clk_clk) begin : mon
        wr_exp_t    e;
        logic [6:0] a;
        if (!reset_reset) begin
            if (wr_valid) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected addr=%0h data=%0h", wr_addr, wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        errors++;
                        $display("FAIL wr_event actual=%0h/%0h required=%0h/%0h",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            if (rd_req) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected addr=%0h", rd_addr);
                end else begin
                    a = exp_rd_q.pop_front();
                    if (rd_addr !== a) begin
                        errors++;
                        $display("FAIL rd_event actual=%0h required=%0h", rd_addr, a);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Mode-0 master: data set while sclk low, MISO sampled at the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        spi_ss_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(4 * HALF);
    endtask

    // Frame-level model: a write stores consecutive bytes; a read requests
    // one address per byte plus a prefetch and returns the bank contents.
    task automatic model_frame(input logic [7:0] cmd);
        logic [6:0] a;
        wr_exp_t    e;
        a = cmd[6:0];
        if (cmd[7]) begin
            for (int i = 0; i <= tx_q.size(); i++) begin
                exp_rd_q.push_back(a);
                if (i < tx_q.size())
                    exp_rx_q.push_back(bank_fixed ? (8'h40 + {1'b0, a}) : ref_mem[a]);
                a = a + 7'd1;
            end
        end else begin
            for (int i = 0; i < tx_q.size(); i++) begin
                e.addr = a;
                e.data = tx_q[i];
                exp_wr_q.push_back(e);
                ref_mem[a] = tx_q[i];
                a = a + 7'd1;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input string tag);
        logic [7:0] rx;
        logic [7:0] exp;
        model_frame(cmd);
        frame_begin();
        spi_bits(cmd, 8, rx);
        check({tag, "_cmd_miso"}, 32'(rx), 32'h0);
        for (int i = 0; i < tx_q.size(); i++) begin
            spi_bits(tx_q[i], 8, rx);
            if (cmd[7]) begin
                exp = exp_rx_q.pop_front();
                check({tag, "_rx"}, 32'(rx), 32'(exp));
            end
        end
        frame_end();
        check({tag, "_wr_pending"}, 32'(exp_wr_q.size()), 32'h0);
        check({tag, "_rd_pending"}, 32'(exp_rd_q.size()), 32'h0);
        tx_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"},    32'(spi_miso),    32'h0);
        check({tag, "_miso_oe"}, 32'(spi_miso_oe), 32'h0);
        check({tag, "_wr_valid"},32'(wr_valid),    32'h0);
        check({tag, "_rd_req"},  32'(rd_req),      32'h0);
        check({tag, "_wr_addr"}, 32'(wr_addr),     32'h0);
        check({tag, "_wr_data"}, 32'(wr_data),     32'h0);
        check({tag, "_rd_addr"}, 32'(rd_addr),     32'h0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [6:0] a0;

        reset_reset = 1'b1;
        spi_sclk    = 1'b0;
        spi_mosi    = 1'b0;
        spi_ss_n    = 1'b1;
        bank_fixed  = 1'b1;
        wait_clk(3);
        check_outputs_zero("reset");
        check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset_reset = 1'b0;
        wait_clk(8);

        // Write two bytes starting at 0x05.
        tx_q = '{8'hA7, 8'h3C};
        run_frame(8'h05, "write");

        // Read two bytes from 0x12 with a fixed-pattern bank.
        tx_q = '{8'h00, 8'hFF};
        run_frame(8'h92, "read");

        // Write across the top of the address space.
        tx_q = '{8'($urandom), 8'($urandom)};
        run_frame(8'h7F, "wrap_wr");

        // Read across the top of the address space.
        tx_q = '{8'h00, 8'h00};
        run_frame(8'hFF, "wrap_rd");

        // Abort a write after 4 data bits: nothing written, back to idle.
        frame_begin();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'hC3, 4, rx);
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(4);
        check("abort_state",   32'(dut.state_q), 32'(ST_IDLE));
        check("abort_miso_oe", 32'(spi_miso_oe), 32'h0);
        wait_clk(4 * HALF);
        check("abort_wr_pending", 32'(exp_wr_q.size()), 32'h0);
        tx_q = '{8'h11};
        run_frame(8'h01, "post_abort");

        // Reset during the second byte of a read; SS_n stays low afterwards.
        exp_rd_q.push_back(7'h12);
        frame_begin();
        spi_bits(8'h92, 8, rx);
        spi_bits(8'hFF, 3, rx);
        @(negedge clk_clk);
        reset_reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        wait_clk(2);
        reset_reset = 1'b0;
        wait_clk(8);
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h80, 8, rx);
        check("midreset_state",      32'(dut.state_q), 32'(ST_IDLE));
        check("midreset_rd_pending", 32'(exp_rd_q.size()), 32'h0);
        frame_end();
        tx_q = '{8'h5A};
        run_frame(8'h20, "post_reset");

        // Random fill of the whole bank, then full read-back, at sclk = clk/8.
        bank_fixed = 1'b0;
        a0 = 7'($urandom);
        for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom));
        run_frame({1'b0, a0}, "rand_wr");
        a0 = 7'($urandom);
        for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom));
        run_frame({1'b1, a0}, "rand_rd");

        wait_clk(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
